// File: rtl/branch_control_unit.sv
// branch_control_unit: control-hazard sequencer selecting stall, predict-not-taken,
// delay-slot or 2-bit BHT/BTB dynamic prediction via Strategy.
module branch_control_unit #(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Strategy,
    input  logic [31:0] IFPC,
    input  logic        IDIsBranch,
    input  logic        EXIsBranch,
    input  logic        EXTaken,
    input  logic [31:0] EXPC,
    input  logic [31:0] EXTarget,
    input  logic        PipeStall,
    output logic        PCHold,
    output logic        Redirect,
    output logic [31:0] RedirectPC,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic [15:0] BranchCount,
    output logic [15:0] FlushCount
);
    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [1:0]        bht_q [BTB_ENTRIES];
    logic [1:0]        bht_d [BTB_ENTRIES];
    logic [TW-1:0]     btb_tag_q [BTB_ENTRIES];
    logic [TW-1:0]     btb_tag_d [BTB_ENTRIES];
    logic [31:0]       btb_tgt_q [BTB_ENTRIES];
    logic [31:0]       btb_tgt_d [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic              id_pred_q, id_pred_d, ex_pred_q, ex_pred_d;
    logic [15:0]       branch_cnt_q, branch_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [IW-1:0]     if_idx, ex_idx;
    logic [TW-1:0]     if_tag, ex_tag;
    logic              if_pred, mispredict, ex_redirect;
    logic              unused_pc_bits;

    assign if_idx         = IFPC[IW+1:2];
    assign ex_idx         = EXPC[IW+1:2];
    assign if_tag         = IFPC[31:IW+2];
    assign ex_tag         = EXPC[31:IW+2];
    assign unused_pc_bits = ^IFPC[1:0];
    assign if_pred        = btb_valid_q[if_idx] && btb_tag_q[if_idx] == if_tag && bht_q[if_idx][1];
    assign mispredict     = EXIsBranch && ex_pred_q != EXTaken;
    assign BranchCount    = branch_cnt_q;
    assign FlushCount     = flush_cnt_q;

    always_comb begin
        PCHold      = 1'b0;
        Redirect    = 1'b0;
        RedirectPC  = '0;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        ex_redirect = 1'b0;
        state_d     = IDLE;
        unique case (Strategy)
            2'b00: begin
                if (state_q == HOLD) begin
                    if (EXTaken) begin
                        Redirect    = 1'b1;
                        RedirectPC  = EXTarget;
                        IFIDFlush   = 1'b1;
                        ex_redirect = 1'b1;
                    end
                end else if (IDIsBranch) begin
                    PCHold    = 1'b1;
                    IFIDFlush = 1'b1;
                    state_d   = HOLD;
                end
            end
            2'b01, 2'b10: begin
                if (EXIsBranch && EXTaken) begin
                    Redirect    = 1'b1;
                    RedirectPC  = EXTarget;
                    IFIDFlush   = 1'b1;
                    IDEXFlush   = Strategy == 2'b01;
                    ex_redirect = 1'b1;
                end
            end
            default: begin
                if (mispredict) begin
                    Redirect    = 1'b1;
                    RedirectPC  = ex_pred_q ? EXPC + 32'd4 : EXTarget;
                    IFIDFlush   = 1'b1;
                    IDEXFlush   = 1'b1;
                    ex_redirect = 1'b1;
                end else if (if_pred) begin
                    Redirect   = 1'b1;
                    RedirectPC = btb_tgt_q[if_idx];
                end
            end
        endcase
        // Outputs are forced quiet for the whole reset window, not just after the edge
        if (reset) begin
            PCHold     = 1'b0;
            Redirect   = 1'b0;
            RedirectPC = '0;
            IFIDFlush  = 1'b0;
            IDEXFlush  = 1'b0;
        end
    end

    always_comb begin
        bht_d       = bht_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        btb_valid_d = btb_valid_q;
        id_pred_d   = 1'b0;
        ex_pred_d   = 1'b0;
        if (Strategy == 2'b11) begin
            // A mispredict flushes both in-flight slots, so both stay cleared
            if (!mispredict) begin
                ex_pred_d = PipeStall ? 1'b0 : id_pred_q;
                id_pred_d = PipeStall ? id_pred_q : if_pred;
            end
            if (EXIsBranch) begin
                bht_d[ex_idx] = EXTaken ? (bht_q[ex_idx] == 2'b11 ? 2'b11 : bht_q[ex_idx] + 2'd1)
                                        : (bht_q[ex_idx] == 2'b00 ? 2'b00 : bht_q[ex_idx] - 2'd1);
                if (EXTaken) begin
                    btb_valid_d[ex_idx] = 1'b1;
                    btb_tag_d[ex_idx]   = ex_tag;
                    btb_tgt_d[ex_idx]   = EXTarget;
                end
            end
        end
        branch_cnt_d = branch_cnt_q + {15'd0, EXIsBranch && branch_cnt_q != 16'hFFFF};
        flush_cnt_d  = flush_cnt_q + {15'd0, ex_redirect && flush_cnt_q != 16'hFFFF};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            btb_valid_q  <= '0;
            id_pred_q    <= 1'b0;
            ex_pred_q    <= 1'b0;
            branch_cnt_q <= '0;
            flush_cnt_q  <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                bht_q[i]     <= 2'b01;
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            btb_valid_q  <= btb_valid_d;
            id_pred_q    <= id_pred_d;
            ex_pred_q    <= ex_pred_d;
            branch_cnt_q <= branch_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            bht_q        <= bht_d;
            btb_tag_q    <= btb_tag_d;
            btb_tgt_q    <= btb_tgt_d;
        end
    end
endmodule

// File: tb/tb_branch_control_unit.sv
// tb_branch_control_unit: directed test-plan scenarios plus randomized traffic,
// checked every cycle against an arithmetic reference model of the sequencer.
module tb_branch_control_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  Strategy = 2'b00;
    logic [31:0] IFPC = '0, EXPC = '0, EXTarget = '0;
    logic        IDIsBranch = 1'b0, EXIsBranch = 1'b0, EXTaken = 1'b0, PipeStall = 1'b0;
    logic        PCHold, Redirect, IFIDFlush, IDEXFlush;
    logic [31:0] RedirectPC;
    logic [15:0] BranchCount, FlushCount;

    branch_control_unit #(.BTB_ENTRIES(16)) dut (
        .clk(clk), .reset(reset), .Strategy(Strategy), .IFPC(IFPC),
        .IDIsBranch(IDIsBranch), .EXIsBranch(EXIsBranch), .EXTaken(EXTaken),
        .EXPC(EXPC), .EXTarget(EXTarget), .PipeStall(PipeStall),
        .PCHold(PCHold), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .BranchCount(BranchCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: saturating ints for counters, plain arrays for the table
    bit          m_hold, m_pid, m_pex;
    int          m_cnt [16];
    bit          m_val [16];
    int unsigned m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_bc, m_fc;
    int          ii, ei;
    bit          hit, e_ph, e_red, e_ff, e_fe, e_exr, n_hold, n_pid, n_pex;
    logic [31:0] e_pc;

    task automatic m_reset();
        m_hold = 0; m_pid = 0; m_pex = 0; m_bc = 0; m_fc = 0;
        for (int i = 0; i < 16; i++) begin
            m_cnt[i] = 1; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        e_ph = 0; e_red = 0; e_ff = 0; e_fe = 0; e_exr = 0; e_pc = 0;
        n_hold = 0; n_pid = 0; n_pex = 0;
        if (reset) m_reset();
        chk("BranchCount", {16'd0, BranchCount}, m_bc);
        chk("FlushCount", {16'd0, FlushCount}, m_fc);
        if (!reset) begin
            ii  = (IFPC / 4) % 16;
            ei  = (EXPC / 4) % 16;
            hit = m_val[ii] && m_tag[ii] == IFPC / 64 && m_cnt[ii] >= 2;
            if (Strategy == 0) begin
                if (m_hold) begin
                    if (EXTaken) begin e_red = 1; e_pc = EXTarget; e_ff = 1; e_exr = 1; end
                end else if (IDIsBranch) begin
                    e_ph = 1; e_ff = 1; n_hold = 1;
                end
            end else if (Strategy != 3) begin
                if (EXIsBranch && EXTaken) begin
                    e_red = 1; e_pc = EXTarget; e_ff = 1; e_fe = (Strategy == 1); e_exr = 1;
                end
            end else begin
                if (EXIsBranch && m_pex != EXTaken) begin
                    e_red = 1; e_ff = 1; e_fe = 1; e_exr = 1;
                    e_pc = m_pex ? EXPC + 4 : EXTarget;
                end else begin
                    if (hit) begin e_red = 1; e_pc = m_tgt[ii]; end
                    n_pex = PipeStall ? 0 : m_pid;
                    n_pid = PipeStall ? m_pid : hit;
                end
                if (EXIsBranch) begin
                    m_cnt[ei] = EXTaken ? (m_cnt[ei] < 3 ? m_cnt[ei] + 1 : 3)
                                        : (m_cnt[ei] > 0 ? m_cnt[ei] - 1 : 0);
                    if (EXTaken) begin
                        m_val[ei] = 1; m_tag[ei] = EXPC / 64; m_tgt[ei] = EXTarget;
                    end
                end
            end
            if (EXIsBranch && m_bc < 65535) m_bc++;
            if (e_exr && m_fc < 65535) m_fc++;
            m_hold = n_hold; m_pid = n_pid; m_pex = n_pex;
        end
        chk("PCHold", PCHold, e_ph);
        chk("Redirect", Redirect, e_red);
        chk("RedirectPC", RedirectPC, e_pc);
        chk("IFIDFlush", IFIDFlush, e_ff);
        chk("IDEXFlush", IDEXFlush, e_fe);
    end

    task automatic drive(input logic [1:0] s, input logic [31:0] ifpc, input bit idb, input bit exb,
                         input bit ext, input logic [31:0] expc, input logic [31:0] extgt,
                         input bit st, input bit rst);
        @(posedge clk);
        #1;
        Strategy = s; IFPC = ifpc; IDIsBranch = idb; EXIsBranch = exb; EXTaken = ext;
        EXPC = expc; EXTarget = extgt; PipeStall = st; reset = rst;
        #2;
    endtask

    task automatic do_reset();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    logic [31:0] pcs [6];
    logic [31:0] tgts [3];
    logic [1:0]  rs;

    initial begin
        pcs[0] = 20; pcs[1] = 36; pcs[2] = 60; pcs[3] = 84; pcs[4] = 84 + 64; pcs[5] = 88;
        tgts[0] = 88; tgts[1] = 200; tgts[2] = 512;

        // Outputs stay quiet under reset even with a taken EX branch present
        drive(2'b01, 44, 1, 1, 1, 36, 80, 0, 1);
        chk("reset_redirect", Redirect, 0);
        chk("reset_ififlush", IFIDFlush, 0);
        do_reset();

        // Stall strategy, taken: hold+flush, then redirect to 88
        drive(2'b00, 24, 1, 0, 0, 0, 0, 0, 0);
        chk("s0_hold", PCHold, 1);
        chk("s0_hold_flush", IFIDFlush, 1);
        drive(2'b00, 24, 0, 1, 1, 20, 88, 0, 0);
        chk("s0_redirect", Redirect, 1);
        chk("s0_rpc", RedirectPC, 88);
        chk("s0_idex", IDEXFlush, 0);
        drive(2'b00, 88, 0, 0, 0, 0, 0, 0, 0);
        chk("s0_flushcnt", FlushCount, 1);
        // Stall strategy, not taken: no redirect, fetch resumes
        drive(2'b00, 24, 1, 0, 0, 0, 0, 0, 0);
        drive(2'b00, 24, 0, 1, 0, 20, 88, 0, 0);
        chk("s0_nt_redirect", Redirect, 0);
        chk("s0_nt_hold", PCHold, 0);

        // Predict-not-taken
        do_reset();
        drive(2'b01, 44, 0, 1, 1, 36, 80, 0, 0);
        chk("s1_ifid", IFIDFlush, 1);
        chk("s1_idex", IDEXFlush, 1);
        chk("s1_rpc", RedirectPC, 80);
        drive(2'b01, 80, 0, 0, 0, 0, 0, 0, 0);
        chk("s1_flushcnt", FlushCount, 1);

        // Delay slot: only IF/ID flushed
        drive(2'b10, 68, 0, 1, 1, 60, 76, 0, 0);
        chk("s2_ifid", IFIDFlush, 1);
        chk("s2_idex", IDEXFlush, 0);
        chk("s2_rpc", RedirectPC, 76);

        // Dynamic: PC 20 -> 88 three times, then not taken
        do_reset();
        drive(2'b11, 20, 0, 0, 0, 0, 0, 0, 0);
        chk("s3_cold", Redirect, 0);
        drive(2'b11, 24, 1, 0, 0, 0, 0, 0, 0);
        drive(2'b11, 28, 0, 1, 1, 20, 88, 0, 0);
        chk("s3_miss1_rpc", RedirectPC, 88);
        chk("s3_miss1_idex", IDEXFlush, 1);
        drive(2'b11, 20, 0, 0, 0, 0, 0, 0, 0);
        chk("s3_pred2_rpc", RedirectPC, 88);
        drive(2'b11, 88, 1, 0, 0, 0, 0, 0, 0);
        drive(2'b11, 92, 0, 1, 1, 20, 88, 0, 0);
        chk("s3_correct", Redirect, 0);
        drive(2'b11, 20, 0, 0, 0, 0, 0, 0, 0);
        chk("s3_pred3", Redirect, 1);
        drive(2'b11, 88, 1, 0, 0, 0, 0, 0, 0);
        drive(2'b11, 92, 0, 1, 0, 20, 88, 0, 0);
        chk("s3_nt_rpc", RedirectPC, 24);
        chk("s3_nt_ifid", IFIDFlush, 1);
        chk("s3_nt_idex", IDEXFlush, 1);
        drive(2'b11, 24, 0, 0, 0, 0, 0, 0, 0);
        chk("s3_flushcnt", FlushCount, 2);
        chk("s3_branchcnt", BranchCount, 3);

        // EX redirect beats PipeStall
        drive(2'b01, 100, 0, 1, 1, 40, 200, 1, 0);
        chk("stall_ifid", IFIDFlush, 1);
        chk("stall_idex", IDEXFlush, 1);
        chk("stall_hold", PCHold, 0);

        // Reset mid-HOLD: quiet immediately and FSM back to IDLE
        do_reset();
        drive(2'b00, 24, 1, 0, 0, 0, 0, 0, 0);
        drive(2'b00, 24, 0, 1, 1, 20, 88, 0, 1);
        chk("rst_hold_redirect", Redirect, 0);
        chk("rst_hold_ifid", IFIDFlush, 0);
        drive(2'b00, 24, 0, 1, 1, 20, 88, 0, 0);
        chk("rst_idle_redirect", Redirect, 0);

        // Leaving stall strategy mid-HOLD drops back to IDLE
        drive(2'b00, 24, 1, 0, 0, 0, 0, 0, 0);
        drive(2'b01, 24, 0, 1, 0, 20, 88, 0, 0);
        drive(2'b00, 24, 0, 0, 1, 20, 88, 0, 0);
        chk("leave_hold", Redirect, 0);

        // Randomized traffic; the negedge model checks every cycle
        rs = 2'b11;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 39) == 0) rs = 2'($urandom_range(0, 3));
            drive(rs, pcs[$urandom_range(0, 5)], $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                  pcs[$urandom_range(0, 5)], tgts[$urandom_range(0, 2)],
                  $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_control_unit.md
# branch_control_unit

Control-hazard sequencer for the five-stage pipelined CPU. It sits beside the IF/ID/EX stages and implements the `Strategy` input: stall, predict-not-taken, delay slot, or dynamic 2-bit prediction with a small BTB. Its outputs are PC hold/redirect and the IF/ID and ID/EX flush signals. Branches are detected in ID and resolved in EX.

## Interface
- `BTB_ENTRIES`, default 16: BHT/BTB depth, power of 2; index = `PC[log2(BTB_ENTRIES)+1:2]`, tag = remaining upper PC bits.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `Strategy` in 2: 00 stall, 01 predict-not-taken, 10 delay slot, 11 dynamic.
- `IFPC` in 32: PC being fetched.
- `IDIsBranch` in 1: beq/bne in ID.
- `EXIsBranch` in 1: beq/bne in EX.
- `EXTaken` in 1: resolved outcome.
- `EXPC` in 32: branch address in EX.
- `EXTarget` in 32: computed target.
- `PipeStall` in 1: load-use stall from hazard unit (IF, ID held).
- `PCHold` out 1: PC not written this cycle.
- `Redirect` out 1: PC loads `RedirectPC` instead of PC+4.
- `RedirectPC` out 32: redirect address.
- `IFIDFlush` out 1: IF/ID latches a NOP.
- `IDEXFlush` out 1: ID/EX latches a NOP.
- `BranchCount` out 16: EX branches seen, saturating.
- `FlushCount` out 16: cycles with any EX-originated redirect, saturating.

## Operation
- All outputs are combinational from registered state and current inputs. Reset forces FSM to IDLE, all BHT counters to 01, all BTB valids to 0, prediction pipe to 0, counters to 0. All outputs are 0 while `reset`=1.
- Strategy 00 (stall), FSM IDLE/HOLD:
  - IDLE with `IDIsBranch`: `PCHold`=1, `IFIDFlush`=1, go to HOLD.
  - HOLD (branch in EX): if `EXTaken`, `Redirect`=1, `RedirectPC`=`EXTarget`, `IFIDFlush`=1. Always returns to IDLE.
- Strategy 01: in EX, if `EXTaken`: `Redirect`=1 to `EXTarget`, `IFIDFlush`=1, `IDEXFlush`=1.
- Strategy 10: in EX, if `EXTaken`: `Redirect`=1 to `EXTarget`, `IFIDFlush`=1 only. The ID instruction is the delay slot and always completes.
- Strategy 11:
  - Fetch-side prediction: BTB hit (valid and tag match on `IFPC`) and counter ≥ 10 predicts taken, giving `Redirect`=1 with `RedirectPC`=BTB target.
  - Prediction bit plus IFPC move IF→ID→EX with the pipeline. They hold on `PipeStall`; the EX slot gets 0 on `PipeStall`.
  - Predicted taken but not taken: redirect to `EXPC`+4, flush IF/ID and ID/EX.
  - Predicted not taken but taken: redirect to `EXTarget`, flush both.
  - Correct prediction: no action.
  - Every EX branch updates its counter, saturating at 00 and 11. On taken it writes the BTB entry (valid, tag, `EXTarget`).
- Priority: EX redirect > IF prediction > `PipeStall`. A flush also clears the prediction-pipe entries being flushed.
- A strategy change takes effect the next cycle. Leaving 11 clears the prediction pipe; BHT/BTB contents are retained. Leaving 00 mid-HOLD returns the FSM to IDLE.
- `BranchCount` increments on each `EXIsBranch` cycle. `FlushCount` increments on each EX-originated redirect. In-flight state is discarded on reset mid-operation.

## Timing
- Prediction lookup has zero latency: `IFPC` → `Redirect` in the same cycle. BHT/BTB writes are visible from the next cycle.
- Penalty, stall strategy: 1 cycle not-taken, 2 cycles taken.
- Penalty, strategy 01: 0 cycles not-taken, 2 cycles taken.
- Penalty, strategy 10: 0 cycles not-taken, 1 cycle taken.
- Penalty, strategy 11: 0 cycles if correct, 2 cycles on mispredict.
- Same-cycle `IDIsBranch` and EX redirect: redirect wins, the ID branch is flushed, and the FSM stays IDLE.
- Counters stop at 16'hFFFF.

## Test plan
- Strategy 00: branch at PC 20, taken to 88. Expect `PCHold`=1 and `IFIDFlush`=1 one cycle, then `Redirect`=1 with `RedirectPC`=88 and `IFIDFlush`=1. Not-taken variant: no redirect, fetch resumes at 24.
- Strategy 01: taken branch at PC 36 to 80. Expect `IFIDFlush`=`IDEXFlush`=1, `RedirectPC`=80, `FlushCount`=1.
- Strategy 10: taken branch at PC 60 to 76. Expect only `IFIDFlush`; the delay slot at 64 is not flushed.
- Strategy 11: branch at PC 20 taken three times.
  - First occurrence mispredicts (`RedirectPC`=`EXTarget`).
  - Third fetch of PC 20 predicts taken (counter 11).
  - Then not taken: redirect to 24 with both flushes.
- Same-cycle EX taken-redirect and `PipeStall`=1: flushes asserted, `PCHold`=0. Assert `reset` mid-HOLD: all outputs 0 immediately, FSM IDLE.
- Run full bubble-sort program under each strategy: array at 512..556 ends ascending, `BranchCount` identical across strategies.
